// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetch stage between imem and decode.
// Issues sequential word-aligned fetches in order, buffers returned words together
// with their PCs in a DEPTH-entry FIFO and hands them to decode over valid/ready.
// An exec redirect flushes the FIFO and discards every response still in flight.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   imem_req_valid/addr/ready           request channel to imem
//   imem_rsp_valid/data                 in-order response channel from imem
//   redirect_valid/pc                   one-cycle branch/jump redirect from exec
//   out_valid/instruction/pc, out_ready instruction stream to decode
//   perf_fetched, perf_dropped          only when FETCH_PERF_EN is defined:
//                                       FIFO pushes / discarded responses + flushed entries
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state, state_d;
  logic [PW-1:0] rd_ptr, rd_d, wr_ptr, wr_d;
  logic [CW-1:0] count, count_d;
  logic [CW-1:0] in_flight, in_flight_d;
  logic [CW-1:0] drop_cnt, drop_cnt_d;
  logic [31:0]   next_pc_d;
  logic [31:0]   rsp_pc, rsp_pc_d;
  logic          req_valid_d;
  logic [31:0]   head_pc_d, head_data_d;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic          req_fire, rsp_accept, rsp_drop, push, pop;
  logic [CW-1:0] flushed;

  // Handshake decode, counter and pointer next-state, registered output precompute
  always_comb begin
    state_d     = state;
    rd_d        = rd_ptr;
    wr_d        = wr_ptr;
    count_d     = count;
    drop_cnt_d  = drop_cnt;
    next_pc_d   = imem_req_addr;
    rsp_pc_d    = rsp_pc;
    head_pc_d   = out_pc;
    head_data_d = out_instruction;
    flushed     = '0;

    req_fire   = imem_req_valid && imem_req_ready;
    // Responses during IDLE belong to a pre-reset request and are ignored
    rsp_accept = imem_rsp_valid && (state != S_IDLE) && (in_flight != '0);
    rsp_drop   = rsp_accept && ((drop_cnt != '0) || redirect_valid);
    push       = rsp_accept && !rsp_drop;
    pop        = out_valid && out_ready;

    in_flight_d = in_flight + CW'(req_fire) - CW'(rsp_accept);

    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old stream
      drop_cnt_d = in_flight_d;
      next_pc_d  = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      flushed    = count - CW'(pop);
    end else begin
      if (rsp_accept && (drop_cnt != '0)) drop_cnt_d = drop_cnt - CW'(1);
      if (req_fire) next_pc_d = imem_req_addr + 32'd4;
      if (push) begin
        rsp_pc_d = rsp_pc + 32'd4;
        wr_d     = wr_ptr + PW'(1);
      end
      if (pop) rd_d = rd_ptr + PW'(1);
      count_d = count + CW'(push) - CW'(pop);
      // New head is either the word being written now or an already stored entry
      if (count_d != '0) begin
        if (push && (wr_ptr == rd_d)) begin
          head_pc_d   = rsp_pc;
          head_data_d = imem_rsp_data;
        end else begin
          head_pc_d   = mem_pc[rd_d];
          head_data_d = mem_data[rd_d];
        end
      end
    end

    case (state)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (redirect_valid && (drop_cnt_d != '0)) state_d = S_FLUSH;
      S_FLUSH: if (drop_cnt_d == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // Outstanding + buffered + droppable never exceeds DEPTH, so the FIFO cannot overflow
    req_valid_d = (state_d != S_IDLE) &&
                  ((SW'(count_d) + SW'(in_flight_d) + SW'(drop_cnt_d)) < SW'(DEPTH));
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      in_flight       <= '0;
      drop_cnt        <= '0;
      rsp_pc          <= RESET_PC;
      imem_req_valid  <= 1'b0;
      imem_req_addr   <= RESET_PC;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
    end else begin
      state           <= state_d;
      rd_ptr          <= rd_d;
      wr_ptr          <= wr_d;
      count           <= count_d;
      in_flight       <= in_flight_d;
      drop_cnt        <= drop_cnt_d;
      rsp_pc          <= rsp_pc_d;
      imem_req_valid  <= req_valid_d;
      imem_req_addr   <= next_pc_d;
      out_valid       <= (count_d != '0);
      out_instruction <= head_data_d;
      out_pc          <= head_pc_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= rsp_pc;
      mem_data[wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters, wrap modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + 32'(rsp_drop) + 32'(flushed);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed bench for fetch_prefetch with an in-order imem model of
// programmable latency. Response word for address a is {16'hBEEF, a[15:0]}.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rsp_sent = 0;
  bit          last_rsp, last_pop;
  pend_t       pend[$];
  logic [31:0] acc[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge once inputs for the coming edge are set; returns at the next negedge
  task automatic tick();
    if (!rst_n) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {16'hBEEF, pend[0].addr[15:0]};
      void'(pend.pop_front());
      rsp_sent++;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (rst_n && imem_req_valid && imem_req_ready) begin
      acc.push_back(imem_req_addr);
      pend.push_back('{imem_req_addr, cyc + lat});
    end
    last_pop = rst_n && out_valid && out_ready;
    last_rsp = imem_rsp_valid;
    if (last_pop) begin
      got_pc.push_back(out_pc);
      got_data.push_back(out_instruction);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    acc.delete();
    got_pc.delete();
    got_data.delete();
    rsp_sent = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_until_got(input int n, input int budget);
    for (int i = 0; i < budget && got_pc.size() < n; i++) tick();
    check("got_count", 32'(got_pc.size() >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] popped;
    int          k, n_pop, n_next;

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    @(negedge clk);

    // 1: reset values, back-to-back fetch, one-cycle latency, no bypass
    do_reset();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instruction, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    tick();
    check("s1_valid0", 32'(imem_req_valid), 32'd1);
    check("s1_addr0", imem_req_addr, 32'h0);
    tick();
    check("s1_addr1", imem_req_addr, 32'h4);
    check("s1_no_bypass", 32'(out_valid), 32'd0);
    tick();
    check("s1_addr2", imem_req_addr, 32'h8);
    check("s1_out_valid", 32'(out_valid), 32'd1);
    check("s1_out_pc0", out_pc, 32'h0);
    run_until_got(3, 20);
    check("s1_pc0", got_pc[0], 32'h0);
    check("s1_pc1", got_pc[1], 32'h4);
    check("s1_pc2", got_pc[2], 32'h8);
    check("s1_data0", got_data[0], 32'hBEEF_0000);
    check("s1_data2", got_data[2], 32'hBEEF_0008);

    // 2: decode stalled, FIFO fills to DEPTH and requests stop
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    repeat (10) tick();
    check("s2_accepts", 32'(acc.size()), 32'd4);
    check("s2_req_valid", 32'(imem_req_valid), 32'd0);
    check("s2_out_valid", 32'(out_valid), 32'd1);
    check("s2_out_pc", out_pc, 32'h0);
    check("s2_out_instr", out_instruction, 32'hBEEF_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && acc.size() < 5; i++) tick();
    check("s2_resume_addr", acc[4], 32'h10);
    run_until_got(2, 20);
    check("s2_pc0", got_pc[0], 32'h0);
    check("s2_pc1", got_pc[1], 32'h4);

    // 3: imem back-pressure holds the address
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    tick();
    tick();
    tick();
    check("s3_addr_pre", imem_req_addr, 32'h8);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s3_stall_addr", imem_req_addr, 32'h8);
      check("s3_stall_valid", 32'(imem_req_valid), 32'd1);
    end
    imem_req_ready = 1'b1;
    tick();
    check("s3_addr_c", imem_req_addr, 32'hC);
    tick();
    check("s3_addr_10", imem_req_addr, 32'h10);
    run_until_got(4, 20);
    check("s3_pc2", got_pc[2], 32'h8);
    check("s3_pc3", got_pc[3], 32'hC);

    // 4: redirect to 0x103 with three requests outstanding, 3-cycle imem
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("s4_accepts_at_r", 32'(acc.size()), 32'd3);
    check("s4_old_addr", acc[2], 32'h8);
    check("s4_drain_valid", 32'(imem_req_valid), 32'd0);
    check("s4_out_valid", 32'(out_valid), 32'd0);
    run_until_got(5, 60);
    check("s4_first_addr", acc[3], 32'h100);
    check("s4_first_pc", got_pc[0], 32'h100);
    check("s4_first_data", got_data[0], 32'hBEEF_0100);
    check("s4_fifth_pc", got_pc[4], 32'h110);
`ifdef FETCH_PERF_EN
    // 6: counters after scenario 4 (FIFO was empty at the redirect)
    check("s6_dropped", perf_dropped, 32'd3);
    check("s6_fetched", perf_fetched, 32'(rsp_sent - 3));
    rst_n = 1'b0;
    tick();
    check("s6_rst_fetched", perf_fetched, 32'd0);
    check("s6_rst_dropped", perf_dropped, 32'd0);
`endif

    // 5: redirect coinciding with a response and an out handshake
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    run_until_got(2, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("s5_pop_in_r", 32'(last_pop), 32'd1);
    check("s5_rsp_in_r", 32'(last_rsp), 32'd1);
    check("s5_out_valid_r1", 32'(out_valid), 32'd0);
    k      = got_pc.size();
    popped = got_pc[k-1];
    run_until_got(k + 2, 30);
    check("s5_target_pc", got_pc[k], 32'h200);
    check("s5_target_data", got_data[k], 32'hBEEF_0200);
    n_pop  = 0;
    n_next = 0;
    foreach (got_pc[i]) begin
      if (got_pc[i] == popped) n_pop++;
      if (got_pc[i] == popped + 32'd4) n_next++;
    end
    check("s5_popped_once", 32'(n_pop), 32'd1);
    check("s5_rsp_unseen", 32'(n_next), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
